// File: rtl/aes_reg_status_mc_pkg.sv
// Shared types and helpers for the multi-share AES register write-status tracker.
package aes_reg_status_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_NEW     = 2'd2
  } aes_reg_status_e;

  // Widest combined mask the all-ones compare helper supports.
  localparam int unsigned MaxMaskW = 64;

  function automatic logic [MaxMaskW-1:0] ones_mask(input int unsigned n);
    logic [MaxMaskW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MaxMaskW; i++) begin
      r[i] = (i < n);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_reg_status_mc_if.sv
// Register-side bundle of the write-status tracker: write/use/clear controls and status readout.
interface aes_reg_status_mc_if #(
  parameter int unsigned Width     = 8,
  parameter int unsigned NumShares = 2,
  parameter int unsigned OutW      = 32,
  parameter int unsigned CntW      = 8
) ();

  logic [NumShares*Width-1:0] we_i;
  logic                       use_i;
  logic                       clear_i;
  logic                       new_o;
  logic                       new_pulse_o;
  logic                       clean_o;
  logic                       err_use_o;
  logic [OutW-1:0]            mask_o;
  logic [CntW-1:0]            load_cnt_o;

  modport master (
    output we_i, use_i, clear_i,
    input  new_o, new_pulse_o, clean_o, err_use_o, mask_o, load_cnt_o
  );

  modport slave (
    input  we_i, use_i, clear_i,
    output new_o, new_pulse_o, clean_o, err_use_o, mask_o, load_cnt_o
  );

endinterface

// File: rtl/aes_reg_status_mc_share.sv
// One share's sticky written-word mask: OR-in writes, reload on use, wipe on clear.
module aes_reg_status_share #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] we,
  input  logic             load,
  input  logic             clear,
  output logic [Width-1:0] mask,
  output logic             full
);

  logic [Width-1:0] mask_reg;
  logic [Width-1:0] mask_next;

  always_comb begin
    mask_next = mask_reg | we;
    if (clear) begin
      mask_next = '0;
    end else if (load) begin
      // Writes landing in the consuming cycle start the next set.
      mask_next = we;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_reg <= '0;
    end else begin
      mask_reg <= mask_next;
    end
  end

  assign mask = mask_reg;
  assign full = &(mask_reg | we);

endmodule

// File: rtl/aes_reg_status_mc.sv
// Multi-share write-status tracker: detects a complete fresh key/IV set and its consumption.
module aes_reg_status_mc
  import aes_reg_status_pkg::*;
#(
  parameter int unsigned Width     = 8,
  parameter int unsigned NumShares = 2,
  parameter int unsigned OutW      = 32,
  parameter int unsigned CntW      = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  aes_reg_status_mc_if.slave  bus
);

  localparam int unsigned MaskW = NumShares * Width;

  if (MaskW > OutW) begin : g_bad_outw
    $fatal(1, "aes_reg_status_mc: NumShares*Width exceeds OutW");
  end
  if (MaskW > MaxMaskW) begin : g_bad_maxw
    $fatal(1, "aes_reg_status_mc: NumShares*Width exceeds MaxMaskW");
  end

  aes_reg_status_e state_reg, state_next;
  logic            pulse_reg, pulse_next;
  logic            err_reg, err_next;
  logic            clean_reg, clean_next;
  logic [CntW-1:0] cnt_reg, cnt_next;

  logic [MaskW-1:0]     mask_all;
  logic [NumShares-1:0] share_full;
  logic                 full;
  logic                 we_any;
  logic                 we_all;
  logic                 share_load;

  // A use only reloads the masks when it actually consumes a set.
  assign share_load = bus.use_i & (state_reg == ST_NEW) & ~bus.clear_i;

  for (genvar gi = 0; gi < NumShares; gi++) begin : g_share
    aes_reg_status_share #(
      .Width (Width)
    ) u_share (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .we     (bus.we_i[gi*Width +: Width]),
      .load   (share_load),
      .clear  (bus.clear_i),
      .mask   (mask_all[gi*Width +: Width]),
      .full   (share_full[gi])
    );
  end

  assign full   = &share_full;
  assign we_any = |bus.we_i;
  assign we_all = (MaxMaskW'(bus.we_i) == ones_mask(MaskW));

  always_comb begin
    state_next = state_reg;
    pulse_next = 1'b0;
    err_next   = 1'b0;
    if (bus.clear_i) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY, ST_PARTIAL: begin
          err_next = bus.use_i;
          if (full) begin
            state_next = ST_NEW;
            pulse_next = 1'b1;
          end else if (we_any) begin
            state_next = ST_PARTIAL;
          end
        end
        ST_NEW: begin
          if (bus.use_i) begin
            // Consumed: the same-cycle writes decide where the next set stands.
            if (we_all) begin
              state_next = ST_NEW;
              pulse_next = 1'b1;
            end else if (we_any) begin
              state_next = ST_PARTIAL;
            end else begin
              state_next = ST_EMPTY;
            end
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    cnt_next   = cnt_reg;
    clean_next = clean_reg | full;
    if (bus.clear_i) begin
      cnt_next   = '0;
      clean_next = 1'b0;
    end else if (pulse_next && (cnt_reg != {CntW{1'b1}})) begin
      cnt_next = cnt_reg + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_EMPTY;
      pulse_reg <= 1'b0;
      err_reg   <= 1'b0;
      clean_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pulse_reg <= pulse_next;
      err_reg   <= err_next;
      clean_reg <= clean_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign bus.new_o       = (state_reg == ST_NEW);
  assign bus.new_pulse_o = pulse_reg;
  assign bus.clean_o     = clean_reg;
  assign bus.err_use_o   = err_reg;
  assign bus.mask_o      = OutW'(mask_all);
  assign bus.load_cnt_o  = cnt_reg;

endmodule

// File: tb/tb_aes_reg_status_mc.sv
// Randomised and directed checks of aes_reg_status_mc against a set-level behavioural model.
module tb_aes_reg_status_mc;

  localparam int unsigned Width     = 8;
  localparam int unsigned NumShares = 2;
  localparam int unsigned OutW      = 32;
  localparam int unsigned CntW      = 8;

  logic clk;
  logic rst_n;

  aes_reg_status_mc_if #(
    .Width(Width), .NumShares(NumShares), .OutW(OutW), .CntW(CntW)
  ) bus ();

  aes_reg_status_mc #(
    .Width(Width), .NumShares(NumShares), .OutW(OutW), .CntW(CntW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int txn   = 0;

  // Model: which words hold fresh data, whether an unconsumed full set exists, and counters.
  bit [15:0] m_written;
  bit        m_fresh;
  bit        m_clean;
  bit        m_pulse;
  bit        m_err;
  int        m_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s txn=%0d got=%h exp=%h", tag, txn, got, exp);
    end
  endtask

  task automatic model_reset();
    m_written = '0;
    m_fresh   = 0;
    m_clean   = 0;
    m_pulse   = 0;
    m_err     = 0;
    m_cnt     = 0;
  endtask

  task automatic model_step(input bit [15:0] we, input bit use_s, input bit clr);
    bit [15:0] merged;
    bit        all_written;
    if (clr) begin
      model_reset();
      return;
    end
    m_pulse     = 0;
    m_err       = 0;
    merged      = m_written | we;
    all_written = ($countones(merged) == 16);
    if (all_written) m_clean = 1;
    if (use_s && m_fresh) begin
      m_written = we;
      m_fresh   = ($countones(we) == 16);
      if (m_fresh) begin
        m_pulse = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end else begin
      if (use_s) m_err = 1;
      m_written = merged;
      if (all_written && !m_fresh) begin
        m_fresh = 1;
        m_pulse = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic check_all();
    check_val("new_o",       32'(bus.new_o),       32'(m_fresh));
    check_val("new_pulse_o", 32'(bus.new_pulse_o), 32'(m_pulse));
    check_val("clean_o",     32'(bus.clean_o),     32'(m_clean));
    check_val("err_use_o",   32'(bus.err_use_o),   32'(m_err));
    check_val("mask_o",      bus.mask_o,           {16'h0, m_written});
    check_val("load_cnt_o",  32'(bus.load_cnt_o),  32'(m_cnt));
  endtask

  task automatic step(input logic [15:0] we, input logic use_s, input logic clr);
    @(negedge clk);
    bus.we_i    = we;
    bus.use_i   = use_s;
    bus.clear_i = clr;
    @(posedge clk);
    txn++;
    model_step(we, use_s, clr);
    #1;
    check_all();
    $display("txn %0d we=%h use=%0b clr=%0b -> new=%0b pls=%0b cln=%0b err=%0b mask=%h cnt=%0d",
             txn, we, use_s, clr, bus.new_o, bus.new_pulse_o, bus.clean_o,
             bus.err_use_o, bus.mask_o, bus.load_cnt_o);
  endtask

  initial begin
    logic [15:0] we_r;
    logic        use_r;
    logic        clr_r;

    rst_n       = 1'b0;
    bus.we_i    = '0;
    bus.use_i   = 1'b0;
    bus.clear_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Two halves complete a set.
    step(16'h00FF, 0, 0);
    check_val("t1_new_early", 32'(bus.new_o), 32'd0);
    step(16'hFF00, 0, 0);
    check_val("t1_new",   32'(bus.new_o),       32'd1);
    check_val("t1_pulse", 32'(bus.new_pulse_o), 32'd1);
    check_val("t1_clean", 32'(bus.clean_o),     32'd1);
    check_val("t1_mask",  bus.mask_o,           32'h0000FFFF);
    check_val("t1_cnt",   32'(bus.load_cnt_o),  32'd1);
    step(16'h0000, 0, 0);
    check_val("t1_pulse_drop", 32'(bus.new_pulse_o), 32'd0);

    // Use with a same-cycle write seeds the next set.
    step(16'h0001, 1, 0);
    check_val("t2_new",   32'(bus.new_o),   32'd0);
    check_val("t2_mask",  bus.mask_o,       32'h00000001);
    check_val("t2_clean", 32'(bus.clean_o), 32'd1);
    step(16'hFFFE, 0, 0);
    check_val("t2_new2",  32'(bus.new_o),      32'd1);
    check_val("t2_cnt",   32'(bus.load_cnt_o), 32'd2);

    // Use while partially written is an error and leaves the mask alone.
    step(16'h0000, 0, 1);
    step(16'h00F0, 0, 0);
    step(16'h0000, 1, 0);
    check_val("t3_err",  32'(bus.err_use_o), 32'd1);
    check_val("t3_mask", bus.mask_o,         32'h000000F0);
    check_val("t3_new",  32'(bus.new_o),     32'd0);
    step(16'h0000, 0, 0);
    check_val("t3_err_drop", 32'(bus.err_use_o), 32'd0);

    // Clear beats simultaneous write and use.
    step(16'hFFFF, 0, 0);
    step(16'hFFFF, 1, 1);
    check_val("t4_new",   32'(bus.new_o),       32'd0);
    check_val("t4_pulse", 32'(bus.new_pulse_o), 32'd0);
    check_val("t4_err",   32'(bus.err_use_o),   32'd0);
    check_val("t4_clean", 32'(bus.clean_o),     32'd0);
    check_val("t4_mask",  bus.mask_o,           32'h0);
    check_val("t4_cnt",   32'(bus.load_cnt_o),  32'd0);

    // Counter saturation over 256 load/use rounds.
    for (int i = 0; i < 256; i++) begin
      step(16'hFFFF, 0, 0);
      step(16'h0000, 1, 0);
    end
    check_val("t5_cnt_sat", 32'(bus.load_cnt_o), 32'h000000FF);
    step(16'hFFFF, 0, 0);
    check_val("t5_cnt_hold", 32'(bus.load_cnt_o), 32'h000000FF);

    // Asynchronous reset between partial writes.
    step(16'h0000, 1, 0);
    step(16'h00FF, 0, 0);
    @(posedge clk);
    #3;
    rst_n       = 1'b0;
    bus.we_i    = '0;
    bus.use_i   = 1'b0;
    bus.clear_i = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(16'hFF00, 0, 0);
    check_val("t6_new",  32'(bus.new_o), 32'd0);
    check_val("t6_mask", bus.mask_o,     32'h0000FF00);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: we_r = 16'h0000;
        1: we_r = 16'hFFFF;
        2: we_r = 16'($urandom);
        3: we_r = 16'h0001 << $urandom_range(0, 15);
        default: we_r = ~(16'h0001 << $urandom_range(0, 15));
      endcase
      use_r = ($urandom_range(0, 3) == 0);
      clr_r = ($urandom_range(0, 19) == 0);
      step(we_r, use_r, clr_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
